ws2812_write_arb: RTL

WS2812_WRITE_ARB -- requirements
Module: ws2812_write_arb

---
 rtl/ws2812_pkg.sv | 17 +
 rtl/ws2812_write_arb_if.sv | 25 ++
 rtl/ws2812_rr_arb.sv | 33 +++
 rtl/ws2812_write_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types for the ws2812 write arbiter: FSM states, GRB colour
// type and a couple of reference colours.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_FILL
  } state_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLACK    = 24'h00_00_00;
  localparam rgb_t RGB_WHITE_LO = 24'h10_10_10;

endpackage

// File: rtl/ws2812_write_arb_if.sv
// One pixel-update requester: valid/ready handshake carrying an LED
// index and a GRB colour.
interface ws2812_write_arb_if;
  import ws2812_pkg::*;

  logic       valid;
  logic       ready;
  logic [7:0] led;
  rgb_t       rgb;

  modport master (
    output valid,
    output led,
    output rgb,
    input  ready
  );

  modport slave (
    input  valid,
    input  led,
    input  rgb,
    output ready
  );

endinterface

// File: rtl/ws2812_rr_arb.sv
// Two-way round-robin arbiter with a one-bit last-grant pointer.
// The pointer advances on every grant; reset favours requester 0.
module ws2812_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_q ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ws2812_write_arb.sv
// Arbitrates two pixel-update requesters onto one ws2812 core write port.
// Optional chain fill mode is built when WS2812_ARB_FILL_EN is defined.
module ws2812_write_arb
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int WR_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  ws2812_write_arb_if.slave req0,
  ws2812_write_arb_if.slave req1,
`ifdef WS2812_ARB_FILL_EN
  input  logic       fill_start,
  input  rgb_t       fill_rgb,
`endif
  output logic [7:0] led_num,
  output rgb_t       rgb_data,
  output logic       write,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] NUM_B    = 8'(NUM_LEDS);
  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [7:0] GAP_LD   = 8'(WR_GAP - 1);

  state_t     state_q, state_d;
  logic [1:0] req_v, gnt;
  logic       arb_en, acc, idx_ok;
  logic       fill_go, fill_more, gap_end;
  logic [7:0] win_led, gap_q;
  rgb_t       win_rgb;

`ifdef WS2812_ARB_FILL_EN
  logic       fill_act_q;
  logic [7:0] fill_idx_q;
  assign fill_go   = fill_start && state_q == ST_IDLE;
  assign fill_more = fill_act_q && fill_idx_q != LAST_IDX;
`else
  assign fill_go   = 1'b0;
  assign fill_more = 1'b0;
`endif

  assign req_v   = {req1.valid, req0.valid};
  assign acc     = |gnt;
  assign idx_ok  = win_led < NUM_B;
  assign gap_end = state_q == ST_GAP && gap_q == 8'd0;

  ws2812_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     (req_v),
    .gnt     (gnt)
  );

  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];

  always_comb begin
    win_led = req0.led;
    win_rgb = req0.rgb;
    unique case (1'b1)
      gnt[1]: begin
        win_led = req1.led;
        win_rgb = req1.rgb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_go) begin
          state_d = ST_FILL;
        end else if (acc && idx_ok) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_GAP;
      ST_FILL:  state_d = ST_GAP;
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = fill_more ? ST_FILL : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are dropped while in reset so nothing can be consumed then.
  always_comb begin
    arb_en = reset_n && state_q == ST_IDLE && !fill_go;
    busy   = state_q != ST_IDLE;
    write  = state_q == ST_WRITE || state_q == ST_FILL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_num    <= 8'd0;
      rgb_data   <= RGB_BLACK;
      err        <= 1'b0;
      gap_q      <= 8'd0;
`ifdef WS2812_ARB_FILL_EN
      fill_act_q <= 1'b0;
      fill_idx_q <= 8'd0;
`endif
    end else begin
      err <= acc && !idx_ok;
      if (acc && idx_ok) begin
        led_num  <= win_led;
        rgb_data <= win_rgb;
      end
      if (write) begin
        gap_q <= GAP_LD;
      end else if (state_q == ST_GAP && gap_q != 8'd0) begin
        gap_q <= gap_q - 8'd1;
      end
`ifdef WS2812_ARB_FILL_EN
      if (fill_go) begin
        fill_act_q <= 1'b1;
        fill_idx_q <= 8'd0;
        led_num    <= 8'd0;
        rgb_data   <= fill_rgb;
      end else if (gap_end && fill_more) begin
        fill_idx_q <= fill_idx_q + 8'd1;
        led_num    <= fill_idx_q + 8'd1;
      end else if (gap_end) begin
        fill_act_q <= 1'b0;
      end
`endif
    end
  end

endmodule
